// File: rtl/puf_pkg.sv
// Shared types and widths for the PUF evaluation controller.
// Challenge/response widths, vote counter width and the controller state encoding.
package puf_pkg;

  localparam int unsigned CHAL_W     = 8;
  localparam int unsigned RESP_W     = 8;
  localparam int unsigned VOTE_CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StPrst,
    StArm,
    StCapture,
    StGap,
    StVote,
    StResp
  } puf_eval_state_t;

endpackage

// File: rtl/puf_majority_vote.sv
// Per-bit ones counters across repeated PUF evaluations.
// Produces the bitwise majority and an all-evaluations-agreed flag.
module puf_majority_vote #(
  parameter int unsigned NUM_EVAL = 5,
  parameter int unsigned RESP_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_acc,
  input  logic [RESP_W-1:0] i_bits,
  output logic [RESP_W-1:0] o_majority,
  output logic              o_stable
);

  localparam int unsigned CntW = puf_pkg::VOTE_CNT_W;
  localparam logic [CntW-1:0] Half = CntW'(NUM_EVAL / 2);
  localparam logic [CntW-1:0] Full = CntW'(NUM_EVAL);

  logic [CntW-1:0] r_cnt [RESP_W];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RESP_W; i++) r_cnt[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < RESP_W; i++) r_cnt[i] <= '0;
    end else if (i_acc) begin
      for (int i = 0; i < RESP_W; i++) r_cnt[i] <= r_cnt[i] + {{(CntW-1){1'b0}}, i_bits[i]};
    end
  end

  always_comb begin
    o_majority = '0;
    o_stable   = 1'b1;
    for (int i = 0; i < RESP_W; i++) begin
      o_majority[i] = (r_cnt[i] > Half);
      if ((r_cnt[i] != '0) && (r_cnt[i] != Full)) o_stable = 1'b0;
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation sequencer: reset the PUF, run it NUM_EVAL times on one challenge,
// then return the majority-voted response with stability and timeout flags.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned NUM_EVAL   = 5,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [CHAL_W-1:0] i_req_challenge,
  input  logic              i_req_orred,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [RESP_W-1:0] o_rsp_data,
  output logic              o_rsp_stable,
  output logic              o_rsp_timeout,
  output logic              o_puf_enable,
  output logic [CHAL_W-1:0] o_puf_challenge,
  output logic              o_puf_orred,
  output logic              o_puf_reset,
  input  logic              i_puf_done,
  input  logic [RESP_W-1:0] i_puf_response
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);
  localparam logic [VOTE_CNT_W-1:0] EvalNum = VOTE_CNT_W'(NUM_EVAL);

  puf_eval_state_t       r_state;
  logic [TmoW-1:0]       r_tmo;
  logic [RstW-1:0]       r_rst_cnt;
  logic [VOTE_CNT_W-1:0] r_eval_cnt;
  logic                  r_done_meta;
  logic                  r_done_s;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [RESP_W-1:0]     r_rsp_data;
  logic                  r_rsp_stable;
  logic                  r_rsp_timeout;
  logic                  r_puf_enable;
  logic [CHAL_W-1:0]     r_puf_challenge;
  logic                  r_puf_orred;
  logic                  r_puf_reset;

  logic                  w_accept;
  logic                  w_capture;
  logic [RESP_W-1:0]     w_majority;
  logic                  w_stable;

  assign w_accept  = (r_state == StIdle) && i_req_valid && r_req_ready;
  assign w_capture = (r_state == StCapture);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done_meta <= 1'b0;
      r_done_s    <= 1'b0;
    end else begin
      r_done_meta <= i_puf_done;
      r_done_s    <= r_done_meta;
    end
  end

  puf_majority_vote #(
    .NUM_EVAL (NUM_EVAL),
    .RESP_W   (RESP_W)
  ) u_vote (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_accept),
    .i_acc      (w_capture),
    .i_bits     (i_puf_response),
    .o_majority (w_majority),
    .o_stable   (w_stable)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= StIdle;
      r_tmo           <= '0;
      r_rst_cnt       <= '0;
      r_eval_cnt      <= '0;
      r_req_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_rsp_stable    <= 1'b0;
      r_rsp_timeout   <= 1'b0;
      r_puf_enable    <= 1'b0;
      r_puf_challenge <= '0;
      r_puf_orred     <= 1'b0;
      r_puf_reset     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_puf_challenge <= i_req_challenge;
            r_puf_orred     <= i_req_orred;
            r_req_ready     <= 1'b0;
            r_puf_reset     <= 1'b1;
            r_rst_cnt       <= '0;
            r_eval_cnt      <= '0;
            r_state         <= StPrst;
          end
        end
        StPrst: begin
          if (r_rst_cnt == RstLast) begin
            r_puf_reset  <= 1'b0;
            r_puf_enable <= 1'b1;
            r_tmo        <= '0;
            r_state      <= StArm;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        StArm: begin
          if (r_done_s) begin
            r_state <= StCapture;
          end else if (r_tmo == TmoLast) begin
            r_puf_enable  <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_stable  <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_state       <= StResp;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StCapture: begin
          r_eval_cnt   <= r_eval_cnt + 1'b1;
          r_puf_enable <= 1'b0;
          r_tmo        <= '0;
          r_state      <= StGap;
        end
        StGap: begin
          if (!r_done_s) begin
            if (r_eval_cnt < EvalNum) begin
              r_puf_enable <= 1'b1;
              r_tmo        <= '0;
              r_state      <= StArm;
            end else begin
              r_state <= StVote;
            end
          end else if (r_tmo == TmoLast) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_stable  <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_state       <= StResp;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StVote: begin
          r_rsp_valid   <= 1'b1;
          r_rsp_data    <= w_majority;
          r_rsp_stable  <= w_stable;
          r_rsp_timeout <= 1'b0;
          r_state       <= StResp;
        end
        StResp: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_stable    = r_rsp_stable;
  assign o_rsp_timeout   = r_rsp_timeout;
  assign o_puf_enable    = r_puf_enable;
  assign o_puf_challenge = r_puf_challenge;
  assign o_puf_orred     = r_puf_orred;
  assign o_puf_reset     = r_puf_reset;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with a behavioural PUF (done delay 5 cycles).
module tb_puf_eval_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_challenge = 8'h00;
  logic       req_orred = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_stable;
  logic       rsp_timeout;
  logic       puf_enable;
  logic [7:0] puf_challenge;
  logic       puf_orred;
  logic       puf_reset;
  logic       puf_done = 1'b0;
  logic [7:0] puf_response;

  int n_tests = 0;
  int n_fail  = 0;

  // PUF model: 0 = constant 3C, 1 = noisy sequence, 2 = never done
  int   mode = 0;
  logic mon_clr = 1'b0;
  int   dly = 0;
  int   resp_idx = 0;
  int   rst_hi = 0;
  int   en_pulses = 0;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;

  puf_eval_ctrl #(
    .NUM_EVAL   (5),
    .TIMEOUT    (1024),
    .RST_CYCLES (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_challenge (req_challenge),
    .i_req_orred     (req_orred),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_rsp_stable    (rsp_stable),
    .o_rsp_timeout   (rsp_timeout),
    .o_puf_enable    (puf_enable),
    .o_puf_challenge (puf_challenge),
    .o_puf_orred     (puf_orred),
    .o_puf_reset     (puf_reset),
    .i_puf_done      (puf_done),
    .i_puf_response  (puf_response)
  );

  function automatic logic [7:0] model_resp(input int m, input int idx);
    if (m != 1) return 8'h3C;
    case (idx)
      0: return 8'h55;
      1: return 8'h55;
      2: return 8'h54;
      3: return 8'h55;
      default: return 8'hD5;
    endcase
  endfunction

  assign puf_response = model_resp(mode, resp_idx);

  always @(posedge clk) begin
    if (!puf_enable) dly <= 0;
    else if (dly < 15) dly <= dly + 1;
    puf_done <= (mode != 2) && puf_enable && (dly >= 4);
    en_prev  <= puf_enable;
    if (mon_clr) begin
      rst_hi    <= 0;
      en_pulses <= 0;
      resp_idx  <= 0;
    end else begin
      if (puf_reset) rst_hi <= rst_hi + 1;
      if (puf_enable && !en_prev) en_pulses <= en_pulses + 1;
      if (!puf_enable && en_prev) resp_idx <= resp_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] chal, input logic orred);
    req_valid     = 1'b1;
    req_challenge = chal;
    req_orred     = orred;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check(tag, {30'd0, rsp_valid, req_ready}, 32'b01);
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, req_ready, rsp_valid, rsp_stable, rsp_timeout, puf_enable, puf_orred,
            puf_reset, rsp_data, puf_challenge};
  endfunction

  initial begin
    int cyc;
    int bad;
    int seen;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), {9'd0, 7'b1000000, 16'h0000});
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_outs(), {9'd0, 7'b1000000, 16'h0000});

    // Clean PUF, challenge AA
    mode = 0;
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    send(8'hAA, 1'b0);
    check("busy_ready_low", {31'd0, req_ready}, 32'd0);
    check("chal_latched", {24'd0, puf_challenge}, 32'hAA);
    wait_rsp("clean_wait", 500, cyc);
    check("clean_data", {24'd0, rsp_data}, 32'h3C);
    check("clean_stable", {31'd0, rsp_stable}, 32'd1);
    check("clean_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("clean_rst_cycles", rst_hi, 4);
    check("clean_en_pulses", en_pulses, 5);

    // Hold response 20 cycles and try to sneak in a second request
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        req_valid     = 1'b1;
        req_challenge = 8'h55;
      end
      if (i == 8) req_valid = 1'b0;
      @(negedge clk);
      if ({rsp_valid, rsp_stable, rsp_timeout, req_ready, rsp_data, puf_challenge}
          !== {4'b1100, 8'h3C, 8'hAA}) bad++;
    end
    check("hold_window_bad_cycles", bad, 0);
    check("hold_chal", {24'd0, puf_challenge}, 32'hAA);
    handshake("hold_handshake");

    // Noisy PUF
    mode = 1;
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    send(8'h33, 1'b0);
    wait_rsp("noisy_wait", 500, cyc);
    check("noisy_data", {24'd0, rsp_data}, 32'h55);
    check("noisy_stable", {31'd0, rsp_stable}, 32'd0);
    check("noisy_timeout", {31'd0, rsp_timeout}, 32'd0);
    handshake("noisy_handshake");

    // Dead PUF: timeout exactly 1024 cycles after ARM entry
    mode = 2;
    send(8'h11, 1'b0);
    cyc = 0;
    while (!puf_enable && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_arm_seen", {31'd0, puf_enable}, 32'd1);
    cyc = 0;
    while (!rsp_valid && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_latency", cyc, 1024);
    check("tmo_flags", {29'd0, rsp_valid, rsp_timeout, rsp_stable}, 32'b110);
    check("tmo_data", {24'd0, rsp_data}, 32'h00);
    handshake("tmo_handshake");

    // Reset during the 3rd evaluation
    mode = 0;
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    send(8'hAA, 1'b0);
    cyc = 0;
    while (!(en_pulses == 3 && puf_enable) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("third_eval_reached", en_pulses, 3);
    rst = 1'b1;
    #1;
    check("midrst_outputs", all_outs(), {9'd0, 7'b1000000, 16'h0000});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    send(8'hAA, 1'b0);
    wait_rsp("after_rst_wait", 500, cyc);
    check("after_rst_data", {24'd0, rsp_data}, 32'h3C);
    check("after_rst_stable", {31'd0, rsp_stable}, 32'd1);
    check("after_rst_en_pulses", en_pulses, 5);
    handshake("after_rst_handshake");

    // Orred mode, challenge 0F held throughout
    send(8'h0F, 1'b1);
    bad = 0;
    cyc = 0;
    while (!rsp_valid && cyc < 500) begin
      if ({puf_orred, puf_challenge} !== {1'b1, 8'h0F}) bad++;
      @(negedge clk);
      cyc++;
    end
    check("orred_wait", {31'd0, rsp_valid}, 32'd1);
    check("orred_bad_cycles", bad, 0);
    check("orred_data", {24'd0, rsp_data}, 32'h3C);
    check("orred_resp_pins", {23'd0, puf_orred, puf_challenge}, {23'd0, 1'b1, 8'h0F});
    handshake("orred_handshake");
    check("orred_idle_pins", {23'd0, puf_orred, puf_challenge}, {23'd0, 1'b1, 8'h0F});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencer for the 8-bit PUF core. It accepts a challenge over a valid/ready request port and resets the PUF. It then runs the PUF NUM_EVAL times on that challenge, waiting for done_sig each time, and returns the bitwise majority-voted response with stability and timeout flags. It sits between the host/bus logic and the PUF instance and owns every PUF control pin.

## Interface
- NUM_EVAL, 5: evaluations per request; odd, 1..15
- TIMEOUT, 1024: max cycles waiting on any done edge; ≥4
- RST_CYCLES, 4: cycles puf_reset is held high per request; ≥1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept
- req_challenge  in  8  challenge for request
- req_orred  in  1  orred mode for request
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  8  majority-voted response
- rsp_stable  out  1  all evaluations agreed bitwise
- rsp_timeout  out  1  evaluation aborted on timeout
- puf_enable  out  1  to PUF enable
- puf_challenge  out  8  to PUF challenge
- puf_orred  out  1  to PUF orred
- puf_reset  out  1  to PUF reset
- puf_done  in  1  from PUF done_sig; asynchronous, synchronized internally
- puf_response  in  8  from PUF response; sampled only in CAPTURE

## Operation
- States: IDLE, PRST, ARM, CAPTURE, GAP, VOTE, RESP.
- IDLE: req_ready=1. When req_valid&&req_ready, latch challenge and orred into registers and clear the vote counters and eval count. → PRST.
- PRST: puf_reset=1 for RST_CYCLES cycles. → ARM.
- ARM: puf_enable=1. Wait for synchronized done (done_s)=1. → CAPTURE. If TIMEOUT cycles elapse first → RESP with rsp_timeout=1 and rsp_data=0.
- CAPTURE: 1 cycle. Add puf_response bits into per-bit counters of width 4 and increment the eval count. → GAP.
- GAP: puf_enable=0. Wait for done_s=0 (same timeout rule). Then → ARM if eval count < NUM_EVAL, else → VOTE.
- VOTE: 1 cycle.
  - rsp_data[i] = (cnt[i] > NUM_EVAL/2).
  - rsp_stable = every cnt[i] ∈ {0, NUM_EVAL}.
  - → RESP.
- RESP: rsp_valid=1. rsp_* are held stable until rsp_ready. → IDLE on the handshake.
- puf_challenge and puf_orred are driven from the latched registers from the cycle after accept and stay constant for the whole request.
- On a timeout, rsp_stable=0.

## Timing
- Reset values:
  - State is IDLE.
  - req_ready=1.
  - rsp_valid, rsp_data, rsp_stable, rsp_timeout = 0.
  - puf_enable, puf_challenge, puf_orred, puf_reset = 0.
  - Counters are 0.
- puf_done passes through a 2-flop synchronizer, so done_s lags puf_done by 2 clk edges.
- Accept at edge T0.
  - puf_reset is high for cycles T0+1 .. T0+RST_CYCLES.
  - puf_enable rises at T0+RST_CYCLES+1.
- For a PUF with done delay D cycles after enable:
  - Per-evaluation cost is D + 2 (sync) + 1 (CAPTURE) + GAP cycles.
  - GAP lasts ≥3 cycles: done fall plus sync.
- rsp_valid rises the cycle after VOTE.
- req_ready=0 from the accept edge until the RESP handshake completes. The next request can be accepted no earlier than the cycle after rsp handshake.
- req_valid while busy is ignored; it is not queued.
- Reset mid-operation immediately returns every output to its reset value. No partial result is emitted.
- The timeout counter clears on each ARM/GAP entry. It saturates, with no wrap.

## Structure
- Shared package puf_pkg holds:
  - CHAL_W=8 and RESP_W=8.
  - The state enum puf_eval_state_t.
  - The vote counter width constant, 4.
- Sub-module puf_majority_vote holds the per-bit counters, clear/accumulate, and the majority/stable outputs. Parameterized by NUM_EVAL and RESP_W.
- The synchronizer is inline: two flops, reset to 0.

## Test plan
- Behavioural PUF model with D=5 that always returns 8'h3C.
  - Stimulus: challenge 8'hAA, NUM_EVAL=5.
  - Required: rsp_data=8'h3C, rsp_stable=1, rsp_timeout=0. puf_reset is high exactly 4 cycles. puf_enable has exactly 5 pulses.
- Noisy model returning 8'h55, 8'h55, 8'h54, 8'h55, 8'hD5.
  - Required: rsp_data=8'h55, rsp_stable=0.
- Model that never raises done.
  - Required: rsp_valid exactly 1024 cycles after ARM entry, with rsp_timeout=1 and rsp_data=0. Controller returns to IDLE after rsp_ready.
- Hold rsp_ready=0 for 20 cycles after rsp_valid, and pulse req_valid with challenge 8'h55 during that window.
  - Required: rsp_* stable throughout, req_ready=0, the second request is not accepted and puf_challenge is unchanged.
- Assert reset during the 3rd evaluation of a request.
  - Required: all outputs at reset values on the next sample and no rsp_valid. A subsequent request with challenge 8'hAA completes normally.
- req_orred=1 with challenge 8'h0F.
  - Required: puf_orred=1 and puf_challenge=8'h0F throughout PRST..GAP, with both latched values held until IDLE.
